// File: rtl/mem_rmw_pkg.sv
// Shared types and helpers for the SRAM read-modify-write adapter.
package mem_rmw_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      MERGE = 1'b1
   } state_e;

   typedef enum logic [1:0] {
      OP_READ    = 2'd0,
      OP_FULL_WR = 2'd1,
      OP_NULL_WR = 2'd2,
      OP_PART_WR = 2'd3
   } op_e;

   function automatic int unsigned strb_width(input int unsigned data_width);
      return data_width / 8;
   endfunction

   // Strobe reductions are passed in so the helper stays width-agnostic.
   function automatic op_e classify(input logic we, input logic strb_all, input logic strb_none);
      op_e op;
      if (!we)            op = OP_READ;
      else if (strb_all)  op = OP_FULL_WR;
      else if (strb_none) op = OP_NULL_WR;
      else                op = OP_PART_WR;
      return op;
   endfunction

endpackage

// File: rtl/sram_byte_merge.sv
// Combinational byte merge: strobed bytes take new data, the rest keep old data.
module sram_byte_merge #(
   parameter  int unsigned DataWidth = 64,
   localparam int unsigned StrbWidth = DataWidth / 8
) (
   input  logic [DataWidth-1:0] old_data,
   input  logic [DataWidth-1:0] new_data,
   input  logic [StrbWidth-1:0] strb,
   output logic [DataWidth-1:0] merged
);

   always_comb begin
      merged = old_data;
      for (int b = 0; b < int'(StrbWidth); b++) begin
         if (strb[b]) merged[b*8 +: 8] = new_data[b*8 +: 8];
      end
   end

endmodule

// File: rtl/sram_rmw_adapter.sv
// Adapts a byte-strobed memory port to an SRAM without byte enables,
// converting partial writes into a two-cycle read-modify-write.
module sram_rmw_adapter
   import mem_rmw_pkg::*;
#(
   parameter  int unsigned AddrWidth = 13,
   parameter  int unsigned DataWidth = 64,
   parameter  int unsigned CntWidth  = 32,
   localparam int unsigned StrbWidth = strb_width(DataWidth)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 req_i,
   output logic                 gnt_o,
   input  logic [AddrWidth-1:0] addr_i,
   input  logic                 we_i,
   input  logic [DataWidth-1:0] wdata_i,
   input  logic [StrbWidth-1:0] strb_i,
   output logic                 rvalid_o,
   output logic [DataWidth-1:0] rdata_o,
   output logic                 sram_req_o,
   output logic                 sram_we_o,
   output logic [AddrWidth-1:0] sram_addr_o,
   output logic [DataWidth-1:0] sram_wdata_o,
   input  logic [DataWidth-1:0] sram_rdata_i,
   output logic [CntWidth-1:0]  rmw_count_o
);

   state_e                 state_q, state_d;
   logic [AddrWidth-1:0]   addr_q;
   logic [DataWidth-1:0]   wdata_q;
   logic [StrbWidth-1:0]   strb_q;
   logic                   rvalid_q, rvalid_d;
   logic                   rd_pend_q, rd_pend_d;
   logic [CntWidth-1:0]    cnt_q;
   logic                   latch_en;
   logic                   rmw_done;
   logic [DataWidth-1:0]   merged;
   op_e                    op;

   sram_byte_merge #(
      .DataWidth (DataWidth)
   ) u_merge (
      .old_data (sram_rdata_i),
      .new_data (wdata_q),
      .strb     (strb_q),
      .merged   (merged)
   );

   assign op = classify(we_i, &strb_i, ~|strb_i);

   // Next state, SRAM command and response scheduling.
   always_comb begin
      state_d      = state_q;
      gnt_o        = 1'b0;
      sram_req_o   = 1'b0;
      sram_we_o    = 1'b0;
      sram_addr_o  = addr_i;
      sram_wdata_o = wdata_i;
      rvalid_d     = 1'b0;
      rd_pend_d    = 1'b0;
      latch_en     = 1'b0;
      rmw_done     = 1'b0;
      case (state_q)
         IDLE: begin
            gnt_o = 1'b1;
            if (req_i) begin
               case (op)
                  OP_READ: begin
                     sram_req_o = 1'b1;
                     rvalid_d   = 1'b1;
                     rd_pend_d  = 1'b1;
                  end
                  OP_FULL_WR: begin
                     sram_req_o = 1'b1;
                     sram_we_o  = 1'b1;
                     rvalid_d   = 1'b1;
                  end
                  OP_NULL_WR: begin
                     rvalid_d = 1'b1;
                  end
                  default: begin
                     sram_req_o = 1'b1;
                     latch_en   = 1'b1;
                     state_d    = MERGE;
                  end
               endcase
            end
         end
         MERGE: begin
            // Old word arrives this cycle; write back the merged word.
            sram_req_o   = 1'b1;
            sram_we_o    = 1'b1;
            sram_addr_o  = addr_q;
            sram_wdata_o = merged;
            rvalid_d     = 1'b1;
            rmw_done     = 1'b1;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         strb_q    <= '0;
         rvalid_q  <= 1'b0;
         rd_pend_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         rvalid_q  <= rvalid_d;
         rd_pend_q <= rd_pend_d;
         if (latch_en) begin
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            strb_q  <= strb_i;
         end
         if (rmw_done && (cnt_q != {CntWidth{1'b1}})) cnt_q <= cnt_q + CntWidth'(1);
      end
   end

   // Read data is only presented for read responses; writes return zero.
   assign rvalid_o    = rvalid_q;
   assign rdata_o     = rd_pend_q ? sram_rdata_i : '0;
   assign rmw_count_o = cnt_q;

endmodule

// File: tb/tb_sram_rmw_adapter.sv
// Scoreboard bench for sram_rmw_adapter with a behavioural single-port SRAM.
module tb_sram_rmw_adapter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req;
   logic        gnt;
   logic [12:0] addr;
   logic        we;
   logic [63:0] wdata;
   logic [7:0]  strb;
   logic        rvalid;
   logic [63:0] rdata;
   logic        sram_req;
   logic        sram_we;
   logic [12:0] sram_addr;
   logic [63:0] sram_wdata;
   logic [63:0] sram_rdata;
   logic [31:0] rmw_count;

   logic [63:0] mem [8192];
   int          wr_count = 0;
   int          total = 0;
   int          bad = 0;
   logic [63:0] exp_q [$];
   logic        last_sreq, last_swe, last_rvalid;

   always #5 clk = ~clk;

   sram_rmw_adapter dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .req_i        (req),
      .gnt_o        (gnt),
      .addr_i       (addr),
      .we_i         (we),
      .wdata_i      (wdata),
      .strb_i       (strb),
      .rvalid_o     (rvalid),
      .rdata_o      (rdata),
      .sram_req_o   (sram_req),
      .sram_we_o    (sram_we),
      .sram_addr_o  (sram_addr),
      .sram_wdata_o (sram_wdata),
      .sram_rdata_i (sram_rdata),
      .rmw_count_o  (rmw_count)
   );

   // Single-port SRAM: write takes effect at the edge, read data one cycle later.
   always @(posedge clk) begin
      if (sram_req) begin
         if (sram_we) begin
            mem[sram_addr] <= sram_wdata;
            wr_count       <= wr_count + 1;
         end else begin
            sram_rdata <= mem[sram_addr];
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Monitor: every response is matched against the oldest expectation.
   always @(negedge clk) begin
      if (rst_n && rvalid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_rvalid", 64'd1, 64'd0);
         end else begin
            chk("response", rdata, exp_q.pop_front());
         end
      end
   end

   task automatic issue(input logic w, input logic [12:0] a, input logic [63:0] d,
                        input logic [7:0] s, input logic [63:0] exp);
      int n;
      req = 1'b1; we = w; addr = a; wdata = d; strb = s;
      n = 0;
      @(negedge clk);
      while (!gnt && n < 8) begin
         @(negedge clk);
         n++;
      end
      chk("grant", 64'(gnt), 64'd1);
      last_sreq   = sram_req;
      last_swe    = sram_we;
      last_rvalid = rvalid;
      exp_q.push_back(exp);
      @(posedge clk);
      #1;
   endtask

   task automatic drop();
      req = 1'b0; we = 1'b0; strb = 8'h00;
   endtask

   task automatic idle(input int n);
      drop();
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      int wr_before;
      rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; strb = '0;
      @(negedge clk);
      chk("rst_gnt", 64'(gnt), 64'd1);
      chk("rst_rvalid", 64'(rvalid), 64'd0);
      chk("rst_rdata", rdata, 64'd0);
      chk("rst_sram_req", 64'(sram_req), 64'd0);
      chk("rst_sram_we", 64'(sram_we), 64'd0);
      chk("rst_count", 64'(rmw_count), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Preload via full writes.
      issue(1'b1, 13'h10, 64'h1122334455667788, 8'hFF, 64'd0);
      issue(1'b1, 13'h30, 64'h0, 8'hFF, 64'd0);
      issue(1'b1, 13'h40, 64'h0123456789ABCDEF, 8'hFF, 64'd0);
      idle(2);

      // Read.
      issue(1'b0, 13'h10, 64'h0, 8'h00, 64'h1122334455667788);
      chk("read_sram_req", 64'(last_sreq), 64'd1);
      idle(2);
      chk("read_count", 64'(rmw_count), 64'd0);

      // Full write, then read back.
      issue(1'b1, 13'h20, 64'hDEADBEEFCAFEF00D, 8'hFF, 64'd0);
      chk("full_wr_we", 64'({last_sreq, last_swe}), 64'd3);
      drop();
      @(negedge clk);
      chk("full_wr_single", 64'(sram_req), 64'd0);
      @(posedge clk); #1;
      issue(1'b0, 13'h20, 64'h0, 8'h00, 64'hDEADBEEFCAFEF00D);
      idle(2);
      chk("full_wr_count", 64'(rmw_count), 64'd0);

      // Partial write: read in accept cycle, merged write in MERGE.
      issue(1'b1, 13'h10, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 64'd0);
      chk("part_rd", 64'({last_sreq, last_swe}), 64'd2);
      drop();
      @(negedge clk);
      chk("merge_gnt", 64'(gnt), 64'd0);
      chk("merge_we", 64'(sram_we), 64'd1);
      chk("merge_addr", 64'(sram_addr), 64'h10);
      chk("merge_wdata", sram_wdata, 64'h11223344AAAAAAAA);
      chk("merge_rvalid", 64'(rvalid), 64'd0);
      @(negedge clk);
      chk("post_merge_gnt", 64'(gnt), 64'd1);
      chk("part_count", 64'(rmw_count), 64'd1);
      @(posedge clk); #1;
      issue(1'b0, 13'h10, 64'h0, 8'h00, 64'h11223344AAAAAAAA);
      idle(2);

      // Back-to-back: read held high behind a partial write.
      issue(1'b1, 13'h30, 64'h5AFFFFFFFFFFFFFF, 8'h80, 64'd0);
      issue(1'b0, 13'h30, 64'h0, 8'h00, 64'h5A00000000000000);
      chk("b2b_overlap", 64'(last_rvalid), 64'd1);
      issue(1'b0, 13'h30, 64'h0, 8'h00, 64'h5A00000000000000);
      idle(3);
      chk("b2b_count", 64'(rmw_count), 64'd2);

      // Null write: no SRAM access, word unchanged.
      issue(1'b1, 13'h40, 64'hFFFFFFFFFFFFFFFF, 8'h00, 64'd0);
      chk("null_sram_req", 64'(last_sreq), 64'd0);
      issue(1'b0, 13'h40, 64'h0, 8'h00, 64'h0123456789ABCDEF);
      idle(3);
      chk("null_count", 64'(rmw_count), 64'd2);

      // Reset during MERGE drops the pending write and its response.
      issue(1'b1, 13'h10, 64'h0, 8'h01, 64'd0);
      drop();
      wr_before = wr_count;
      #1;
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      chk("mid_rst_gnt", 64'(gnt), 64'd1);
      chk("mid_rst_sram_we", 64'(sram_we), 64'd0);
      chk("mid_rst_rvalid", 64'(rvalid), 64'd0);
      chk("mid_rst_count", 64'(rmw_count), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      chk("mid_rst_no_write", 64'(wr_count), 64'(wr_before));
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_gnt", 64'(gnt), 64'd1);
      chk("post_rst_rvalid", 64'(rvalid), 64'd0);
      @(posedge clk); #1;
      issue(1'b0, 13'h10, 64'h0, 8'h00, 64'h11223344AAAAAAAA);
      idle(3);
      chk("post_rst_count", 64'(rmw_count), 64'd0);
      chk("queue_drained", 64'(exp_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
